// File: rtl/clock_period_meter_pkg.sv
// -----------------------------------------------------------------------------
// clock_period_meter_pkg
// Shared constants for the clock period meter: default parameter values and
// the FSM state encoding used by clock_period_meter.
// -----------------------------------------------------------------------------
package clock_period_meter_pkg;

  // Default width of the cycle counter and the result outputs
  localparam int DEFAULT_CNT_WIDTH = 28;

  // Default count at which a measurement is abandoned (all ones at 28 bits)
  localparam logic [27:0] DEFAULT_TIMEOUT = 28'hFFFFFFF;

  // Default number of flops in the inclk synchronizer
  localparam int DEFAULT_SYNC_STAGES = 2;

  // FSM state encoding
  typedef logic [2:0] state_t;

  localparam state_t IDLE      = 3'd0;
  localparam state_t ARM       = 3'd1;
  localparam state_t WAIT_RISE = 3'd2;
  localparam state_t MEAS_HIGH = 3'd3;
  localparam state_t MEAS_LOW  = 3'd4;
  localparam state_t DONE      = 3'd5;

endpackage

// File: rtl/sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
// Brings an asynchronous level into the clk domain through a flop chain and
// produces registered single-cycle pulses on its rising and falling edges.
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   async_in  in   level asynchronous to clk
//   sync      out  synchronized level (last flop of the chain)
//   rise      out  one-cycle pulse after a 0->1 transition of sync
//   fall      out  one-cycle pulse after a 1->0 transition of sync
//
// Both pulses trail the async_in transition by SYNC_STAGES+1 cycles, so an
// interval measured between any two edges carries no fixed offset.
// -----------------------------------------------------------------------------
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Shift the input through the synchronizer; prev holds the synchronized
  // level from the previous cycle so the edge pulses are registered too.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
      prev  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], async_in};
      prev  <= chain[SYNC_STAGES-1];
      rise  <= chain[SYNC_STAGES-1] & ~prev;
      fall  <= ~chain[SYNC_STAGES-1] & prev;
    end
  end

  assign sync = chain[SYNC_STAGES-1];

endmodule

// File: rtl/clock_period_meter.sv
// -----------------------------------------------------------------------------
// clock_period_meter
// One-shot measurement of a slow clock-like input in the clk domain. After a
// start request the block waits for inclk to be low, then for a rising edge,
// and reports the high time and full period in clk cycles through a
// valid/ready handshake. A measurement that reaches TIMEOUT counts is
// reported with timeout=1 and zero results.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   inclk      in   signal under measurement, asynchronous to clk
//   start      in   one-cycle request, honoured only when idle
//   busy       out  high in every state except IDLE
//   valid      out  result available, held until accepted
//   ready      in   consumer accepts on a clk edge where valid & ready
//   period     out  clk cycles between consecutive rising edges of inclk
//   high_time  out  clk cycles from a rising edge to the next falling edge
//   timeout    out  qualifies valid: the measurement was abandoned
// -----------------------------------------------------------------------------
module clock_period_meter
  import clock_period_meter_pkg::*;
#(
  parameter int                   CNT_WIDTH   = DEFAULT_CNT_WIDTH,
  parameter logic [CNT_WIDTH-1:0] TIMEOUT     = CNT_WIDTH'(DEFAULT_TIMEOUT),
  parameter int                   SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inclk,
  input  logic                 start,
  output logic                 busy,
  output logic                 valid,
  input  logic                 ready,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 timeout
);

  state_t               state;
  logic [CNT_WIDTH-1:0] counter;
  logic [CNT_WIDTH-1:0] counter_inc;
  logic                 at_timeout;
  logic                 in_sync;
  logic                 in_rise;
  logic                 in_fall;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_detect (
    .clk      (clk),
    .reset    (reset),
    .async_in (inclk),
    .sync     (in_sync),
    .rise     (in_rise),
    .fall     (in_fall)
  );

  // The counter saturates at TIMEOUT so it can never wrap back through small
  // values while the FSM is deciding to give up.
  assign at_timeout  = (counter == TIMEOUT);
  assign counter_inc = at_timeout ? counter : counter + CNT_WIDTH'(1);

  // Measurement FSM, cycle counter and result registers. In every measuring
  // state a qualifying edge is checked before the timeout so that an edge
  // arriving on the very last count still produces a real result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      counter   <= '0;
      period    <= '0;
      high_time <= '0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= ARM;
            counter <= '0;
          end
        end

        // Waiting for a low level first stops an input that is already high
        // from being mistaken for a fresh rising edge.
        ARM: begin
          counter <= counter_inc;
          if (!in_sync) begin
            state <= WAIT_RISE;
          end else if (at_timeout) begin
            state     <= DONE;
            timeout   <= 1'b1;
            period    <= '0;
            high_time <= '0;
          end
        end

        // The rising edge starts the interval: the cycle after it counts as 1.
        WAIT_RISE: begin
          if (in_rise) begin
            state   <= MEAS_HIGH;
            counter <= CNT_WIDTH'(1);
          end else begin
            counter <= counter_inc;
            if (at_timeout) begin
              state     <= DONE;
              timeout   <= 1'b1;
              period    <= '0;
              high_time <= '0;
            end
          end
        end

        MEAS_HIGH: begin
          counter <= counter_inc;
          if (in_fall) begin
            state     <= MEAS_LOW;
            high_time <= counter;
          end else if (at_timeout) begin
            state     <= DONE;
            timeout   <= 1'b1;
            period    <= '0;
            high_time <= '0;
          end
        end

        MEAS_LOW: begin
          counter <= counter_inc;
          if (in_rise) begin
            state   <= DONE;
            period  <= counter;
            timeout <= 1'b0;
          end else if (at_timeout) begin
            state     <= DONE;
            timeout   <= 1'b1;
            period    <= '0;
            high_time <= '0;
          end
        end

        // Results stay frozen here until the consumer takes them.
        DONE: begin
          if (ready) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status outputs decode straight from the state register.
  assign valid = (state == DONE);
  assign busy  = (state != IDLE);

endmodule
